// File: rtl/gol_generation_ctrl.sv
// One Game-of-Life generation over a toroidal grid: rows stream from the front
// bank through a 3-row window and the next-state rows go to the back bank.

module next_cell_state (
    input  logic       i_cell,
    input  logic [7:0] i_nbrs,
    output logic       o_next
);
    logic [3:0] cnt;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < 8; i++) cnt = cnt + {3'b000, i_nbrs[i]};
        o_next = (cnt == 4'd3) || (i_cell && (cnt == 4'd2));
    end
endmodule

module gol_generation_ctrl #(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 24,
    parameter int ROW_W  = $clog2(HEIGHT),
    parameter int GEN_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_front_bank,
    output logic             o_rd_en,
    output logic             o_rd_bank,
    output logic [ROW_W-1:0] o_rd_row,
    input  logic [WIDTH-1:0] i_rd_data,
    output logic             o_wr_en,
    output logic             o_wr_bank,
    output logic [ROW_W-1:0] o_wr_row,
    output logic [WIDTH-1:0] o_wr_data,
    output logic [GEN_W-1:0] o_gen_count
);
    localparam int CNT_W = $clog2(HEIGHT + 7);
    localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(HEIGHT + 2);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(HEIGHT + 5);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_en_q, rd_en_d;
    logic [ROW_W-1:0] rd_row_q, rd_row_d;
    logic             rd_vld_q, rd_vld_d;
    logic [WIDTH-1:0] top_q, top_d, mid_q, mid_d, bot_q, bot_d;
    logic [1:0]       fill_q, fill_d;
    logic [ROW_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             wr_fin_q, wr_fin_d;
    logic             wr_en_q, wr_en_d;
    logic [ROW_W-1:0] wr_row_q, wr_row_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic             front_q, front_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [WIDTH-1:0] next_row;

    // Column c sees columns c-1 and c+1 modulo WIDTH in all three window rows.
    for (genvar c = 0; c < WIDTH; c++) begin : g_col
        localparam int L = (c + WIDTH - 1) % WIDTH;
        localparam int R = (c + 1) % WIDTH;
        next_cell_state u_cell (
            .i_cell (mid_q[c]),
            .i_nbrs ({top_q[L], top_q[c], top_q[R], mid_q[L], mid_q[R],
                      bot_q[L], bot_q[c], bot_q[R]}),
            .o_next (next_row[c])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_en_d   = 1'b0;
        rd_row_d  = rd_row_q;
        rd_vld_d  = rd_en_q;
        top_d     = top_q;
        mid_d     = mid_q;
        bot_d     = bot_q;
        fill_d    = fill_q;
        wr_ptr_d  = wr_ptr_q;
        wr_fin_d  = wr_fin_q;
        wr_en_d   = 1'b0;
        wr_row_d  = wr_row_q;
        wr_data_d = wr_data_q;
        front_d   = front_q;
        gen_d     = gen_q;

        if (rd_vld_q) begin
            top_d  = mid_q;
            mid_d  = bot_q;
            bot_d  = i_rd_data;
            fill_d = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
        end

        // Window holds rows r-1, r, r+1 once full; emit exactly HEIGHT rows.
        if (fill_q == 2'd3 && !wr_fin_q && (state_q == S_READ || state_q == S_DRAIN)) begin
            wr_en_d   = 1'b1;
            wr_row_d  = wr_ptr_q;
            wr_data_d = next_row;
            if (wr_ptr_q == ROW_LAST) wr_fin_d = 1'b1;
            else                      wr_ptr_d = wr_ptr_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d  = S_READ;
                    cnt_d    = CNT_W'(1);
                    rd_en_d  = 1'b1;
                    rd_row_d = ROW_LAST;
                    fill_d   = '0;
                    wr_ptr_d = '0;
                    wr_fin_d = 1'b0;
                end
            end
            S_READ: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RD_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_en_d  = 1'b1;
                    rd_row_d = (rd_row_q == ROW_LAST) ? '0 : rd_row_q + 1'b1;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                    front_d = ~front_q;
                    gen_d   = gen_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_row_q  <= '0;
            rd_vld_q  <= 1'b0;
            top_q     <= '0;
            mid_q     <= '0;
            bot_q     <= '0;
            fill_q    <= '0;
            wr_ptr_q  <= '0;
            wr_fin_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_row_q  <= '0;
            wr_data_q <= '0;
            front_q   <= 1'b0;
            gen_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_en_q   <= rd_en_d;
            rd_row_q  <= rd_row_d;
            rd_vld_q  <= rd_vld_d;
            top_q     <= top_d;
            mid_q     <= mid_d;
            bot_q     <= bot_d;
            fill_q    <= fill_d;
            wr_ptr_q  <= wr_ptr_d;
            wr_fin_q  <= wr_fin_d;
            wr_en_q   <= wr_en_d;
            wr_row_q  <= wr_row_d;
            wr_data_q <= wr_data_d;
            front_q   <= front_d;
            gen_q     <= gen_d;
        end
    end

    assign o_busy       = (state_q != S_IDLE);
    assign o_done       = (state_q == S_DONE);
    assign o_front_bank = front_q;
    assign o_rd_en      = rd_en_q;
    assign o_rd_bank    = front_q;
    assign o_rd_row     = rd_row_q;
    assign o_wr_en      = wr_en_q;
    assign o_wr_bank    = ~front_q;
    assign o_wr_row     = wr_row_q;
    assign o_wr_data    = wr_data_q;
    assign o_gen_count  = gen_q;
endmodule

// File: tb/tb_gol_generation_ctrl.sv
// Bench for gol_generation_ctrl on an 8x6 torus with a behavioural two-bank
// row memory and a scoreboard of expected next-generation rows.

module tb_gol_generation_ctrl;
  localparam int WIDTH  = 8;
  localparam int HEIGHT = 6;
  localparam int ROW_W  = 3;
  localparam int GEN_W  = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic             o_busy, o_done, o_front_bank;
  logic             o_rd_en, o_rd_bank, o_wr_en, o_wr_bank;
  logic [ROW_W-1:0] o_rd_row, o_wr_row;
  logic [WIDTH-1:0] rd_data, o_wr_data;
  logic [GEN_W-1:0] o_gen_count;

  logic [WIDTH-1:0] mem [2][HEIGHT];
  logic [WIDTH-1:0] ref_grid [HEIGHT];
  logic [WIDTH-1:0] exp_q [$];
  logic             load_en = 1'b0;
  logic             load_bank = 1'b0;
  int               load_row = 0;
  logic [WIDTH-1:0] load_data = '0;

  int n_checks = 0;
  int n_errors = 0;
  int rd_idx = 0;
  int wr_idx = 0;
  int cyc = 0;
  logic       exp_front = 1'b0;
  logic [GEN_W-1:0] exp_gen = '0;

  gol_generation_ctrl #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ROW_W(ROW_W), .GEN_W(GEN_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done), .o_front_bank(o_front_bank),
    .o_rd_en(o_rd_en), .o_rd_bank(o_rd_bank), .o_rd_row(o_rd_row), .i_rd_data(rd_data),
    .o_wr_en(o_wr_en), .o_wr_bank(o_wr_bank), .o_wr_row(o_wr_row), .o_wr_data(o_wr_data),
    .o_gen_count(o_gen_count)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // row memory: one-cycle read latency, bench loads through a side port
  always @(posedge clk) begin
    if (o_rd_en) rd_data <= mem[o_rd_bank][o_rd_row];
    if (o_wr_en) mem[o_wr_bank][o_wr_row] <= o_wr_data;
    if (load_en) mem[load_bank][load_row] <= load_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && o_rd_en) begin
      check("rd_bank", 32'(o_rd_bank), 32'(exp_front));
      check("rd_row", 32'(o_rd_row), (rd_idx == 0) ? 32'(HEIGHT - 1) : 32'((rd_idx - 1) % HEIGHT));
      rd_idx++;
    end
    if (rst_n && o_wr_en) begin
      check("wr_bank", 32'(o_wr_bank), 32'(!exp_front));
      check("wr_row", 32'(o_wr_row), 32'(wr_idx));
      if (exp_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
      else check("wr_data", 32'(o_wr_data), 32'(exp_q.pop_front()));
      wr_idx++;
    end
  end

  function automatic logic [WIDTH-1:0] life_row(input int r);
    logic [WIDTH-1:0] res;
    int n;
    res = '0;
    for (int c = 0; c < WIDTH; c++) begin
      n = 0;
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++)
          if (dr != 0 || dc != 0)
            n += int'(ref_grid[(r + dr + HEIGHT) % HEIGHT][(c + dc + WIDTH) % WIDTH]);
      res[c] = (n == 3) || (ref_grid[r][c] && n == 2);
    end
    return res;
  endfunction

  task automatic push_expected();
    logic [WIDTH-1:0] nxt [HEIGHT];
    for (int r = 0; r < HEIGHT; r++) begin
      nxt[r] = life_row(r);
      exp_q.push_back(nxt[r]);
    end
    for (int r = 0; r < HEIGHT; r++) ref_grid[r] = nxt[r];
  endtask

  task automatic load_row_task(input logic bank, input int r, input logic [WIDTH-1:0] d);
    @(negedge clk);
    load_en = 1'b1; load_bank = bank; load_row = r; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic load_grid(input logic [WIDTH-1:0] g [HEIGHT]);
    for (int r = 0; r < HEIGHT; r++) begin
      load_row_task(exp_front, r, g[r]);
      ref_grid[r] = g[r];
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_front"}, 32'(o_front_bank), 32'd0);
    check({tag, "_rd_en"}, 32'(o_rd_en), 32'd0);
    check({tag, "_rd_row"}, 32'(o_rd_row), 32'd0);
    check({tag, "_wr_en"}, 32'(o_wr_en), 32'd0);
    check({tag, "_wr_row"}, 32'(o_wr_row), 32'd0);
    check({tag, "_wr_data"}, 32'(o_wr_data), 32'd0);
    check({tag, "_gen"}, 32'(o_gen_count), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    exp_front = 1'b0;
    exp_gen = '0;
    @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
  endtask

  task automatic post_done_checks();
    check("wr_count", 32'(wr_idx), 32'(HEIGHT));
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("front_swap", 32'(o_front_bank), 32'(!exp_front));
    check("gen_inc", 32'(o_gen_count), 32'(exp_gen + 1'b1));
    exp_front = !exp_front;
    exp_gen = exp_gen + 1'b1;
  endtask

  // one generation from a start pulse; optional ignored pulses at cycle 3 and in DONE
  task automatic run_gen(input bit pulses);
    int k;
    bit seen;
    push_expected();
    rd_idx = 0; wr_idx = 0;
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    k = 1; seen = 1'b0;
    check("busy_c1", 32'(o_busy), 32'd1);
    while (k < HEIGHT + 20) begin
      if (o_done) begin seen = 1'b1; break; end
      @(negedge clk);
      k++;
      i_start = pulses && (k == 3);
    end
    i_start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("done_cycle", 32'(k), 32'(HEIGHT + 6));
    check("busy_done", 32'(o_busy), 32'd1);
    post_done_checks();
    if (pulses) i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("done_pulse", 32'(o_done), 32'd0);
    check("idle_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    check("no_restart", 32'(o_busy), 32'd0);
  endtask

  logic [WIDTH-1:0] g [HEIGHT];
  logic [WIDTH-1:0] saved [HEIGHT];

  initial begin
    int k, last, seen;
    repeat (2) @(negedge clk);
    check_zero("por");
    rst_n = 1'b1;

    // blinker: horizontal -> vertical -> horizontal
    g = '{8'h00, 8'h00, 8'h0E, 8'h00, 8'h00, 8'h00};
    load_grid(g);
    run_gen(1'b0);
    for (int r = 0; r < HEIGHT; r++)
      check("blinker_bank1", 32'(mem[1][r]), (r >= 1 && r <= 3) ? 32'h04 : 32'h00);
    run_gen(1'b0);
    check("blinker_back", 32'(mem[0][2]), 32'h0E);
    check("blinker_gen", 32'(o_gen_count), 32'd2);
    check("blinker_front", 32'(o_front_bank), 32'd0);

    // block still life over three generations
    do_reset();
    g = '{8'h00, 8'h06, 8'h06, 8'h00, 8'h00, 8'h00};
    load_grid(g);
    repeat (3) run_gen(1'b0);
    check("block_gen", 32'(o_gen_count), 32'd3);
    for (int r = 0; r < HEIGHT; r++)
      check("block_rows", 32'(mem[o_front_bank][r]), (r == 1 || r == 2) ? 32'h06 : 32'h00);

    // vertical blinker on column 0 across the row seam; protocol pulses ignored
    do_reset();
    g = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
    load_grid(g);
    run_gen(1'b1);
    for (int r = 0; r < HEIGHT; r++)
      check("wrap_rows", 32'(mem[1][r]), (r == 0) ? 32'h83 : 32'h00);

    // start held high: back-to-back generations every HEIGHT+7 cycles
    push_expected();
    rd_idx = 0; wr_idx = 0;
    @(negedge clk); i_start = 1'b1;
    last = 0;
    for (int gen = 0; gen < 3; gen++) begin
      k = 0; seen = 0;
      while (k < 2 * HEIGHT + 20) begin
        @(negedge clk); k++;
        if (o_done) begin seen = 1; break; end
      end
      check("held_done_seen", 32'(seen), 32'd1);
      if (gen > 0) check("held_period", 32'(cyc - last), 32'(HEIGHT + 7));
      last = cyc;
      post_done_checks();
      rd_idx = 0; wr_idx = 0;
      if (gen < 2) push_expected();
      else i_start = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("held_stop", 32'(o_busy), 32'd0);

    // reset during a generation aborts and leaves the front bank intact
    do_reset();
    for (int r = 0; r < HEIGHT; r++) g[r] = WIDTH'($urandom_range(0, 255));
    load_grid(g);
    saved = ref_grid;
    push_expected();
    rd_idx = 0; wr_idx = 0;
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    k = 1;
    while (k < 7) begin @(negedge clk); k++; end
    #2;
    check("abort_wr_active", 32'(o_wr_en), 32'd1);
    check("abort_wr_count", 32'(wr_idx), 32'd2);
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    exp_q.delete();
    ref_grid = saved;
    exp_front = 1'b0;
    exp_gen = '0;
    @(negedge clk); rst_n = 1'b1;
    run_gen(1'b0);
    check("after_abort_gen", 32'(o_gen_count), 32'd1);

    // random grids over 50 generations
    do_reset();
    for (int r = 0; r < HEIGHT; r++) g[r] = WIDTH'($urandom_range(0, 255));
    load_grid(g);
    for (int n = 0; n < 50; n++) begin
      if (n == 25) begin
        // reseed the live grid mid-run so dead patterns do not dominate
        for (int r = 0; r < HEIGHT; r++) g[r] = WIDTH'($urandom_range(0, 255));
        load_grid(g);
      end
      run_gen(n[0]);
    end
    check("random_gen", 32'(o_gen_count), 32'd50);
    for (int r = 0; r < HEIGHT; r++)
      check("random_final", 32'(mem[o_front_bank][r]), 32'(ref_grid[r]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/gol_generation_ctrl.md
Name: gol_generation_ctrl

Overview:
Sequences one Game-of-Life generation over a toroidal grid held in an external double-buffered row memory. Streams rows from the front bank through a 3-row sliding window and evaluates a whole row per cycle with WIDTH instances of next_cell_state. Writes the resulting row to the back bank, then swaps banks. Sits between the frame/grid RAM and the top-level run/step control.

Parameters:
WIDTH, 32, cells per row; one row equals one memory word.
HEIGHT, 24, rows per grid; must be at least 3.
ROW_W, $clog2(HEIGHT), row address width.
GEN_W, 16, generation counter width.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  request one generation; sampled only in IDLE
o_busy  out  1  high from the cycle after start acceptance through the DONE cycle
o_done  out  1  one-cycle pulse when a generation completes
o_front_bank  out  1  bank holding the current displayed generation
o_rd_en  out  1  row read strobe
o_rd_bank  out  1  read bank; always equals o_front_bank
o_rd_row  out  ROW_W  read row address
i_rd_data  in  WIDTH  read data, valid exactly 1 cycle after o_rd_en
o_wr_en  out  1  row write strobe
o_wr_bank  out  1  write bank; always equals ~o_front_bank
o_wr_row  out  ROW_W  write row address
o_wr_data  out  WIDTH  next-generation row; bit c is column c
o_gen_count  out  GEN_W  completed generations, wraps modulo 2^GEN_W

Behaviour:
- Reset (async assert, sync deassert at the top level): state=IDLE. All outputs 0: o_busy, o_done, o_front_bank, o_rd_en, o_rd_row, o_wr_en, o_wr_row, o_wr_data, o_gen_count. Window registers are cleared.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE -> READ when i_start=1 (call this cycle 0).
  - READ lasts HEIGHT+2 cycles (cycles 1..HEIGHT+2), then goes to DRAIN.
  - DRAIN lasts 3 cycles, then goes to DONE.
  - DONE lasts 1 cycle, then returns to IDLE.
- Read sequence (registered outputs, o_rd_en=1 on every READ cycle): rows HEIGHT-1, 0, 1, 2, ..., HEIGHT-1, 0.
- Window: the 3-row shift register top<-mid<-bot<-i_rd_data captures at the end of each cycle in which read data is valid (cycles 2..HEIGHT+3). A 2-bit fill counter marks the window valid after 3 captures.
- Compute: for each column c, the cell is mid[c]; the 8 neighbours are top/mid/bot at columns c-1, c, c+1 modulo WIDTH, excluding mid[c]. Column wrap: column 0 uses WIDTH-1 as its left neighbour, and column WIDTH-1 uses 0 as its right neighbour. Neighbour bit order is irrelevant; only the population count matters.
- Write (registered): o_wr_en=1, o_wr_row=r, o_wr_data=computed row, for r=0..HEIGHT-1 on cycles 6..HEIGHT+5. One row per cycle, with no gaps.
- DONE cycle (cycle HEIGHT+6): o_done=1, o_front_bank toggles, o_gen_count increments. These three updates are visible in the same cycle.
- o_busy=1 from cycle 1 through cycle HEIGHT+6 inclusive.
- i_start while busy or in DONE is ignored, not queued. i_start held high in IDLE starts back-to-back generations; there is one IDLE cycle between generations.
- The front bank is never written during a generation; o_rd_bank and o_wr_bank never coincide.
- Asserting i_rst_n low mid-generation aborts immediately. All outputs return to reset values, including o_front_bank=0. A partially written back bank is discarded and not swapped in.
- Total latency: start accepted at cycle 0 -> o_done at cycle HEIGHT+6.

Test Plan:
- Blinker, WIDTH=5, HEIGHT=5, bank0 = rows {00000,00000,01110,00000,00000}. Pulse i_start -> writes to bank1 on cycles 6..10 with rows {00000,00100,00100,00100,00000}; o_done at cycle 11; o_front_bank=1; o_gen_count=1. A second start restores the original pattern into bank0; o_front_bank=0; o_gen_count=2.
- Block still life, 2x2 at rows 1-2, cols 1-2 (rows 00110): after 3 generations every row written equals its input; o_gen_count=3.
- Toroidal wrap, WIDTH=5, HEIGHT=5, vertical blinker at column 0 rows 4,0,1: next generation is row0=10011 (cols 4,0,1 set), all other rows 0. This checks both column wrap and row wrap.
- Protocol: i_start pulsed again at cycles 3 and HEIGHT+6 -> ignored; exactly HEIGHT writes, one o_done, o_rd_bank != o_wr_bank throughout. i_start held high -> o_done pulses every HEIGHT+7 cycles.
- Reset mid-op: deassert i_rst_n at cycle 7 -> all outputs 0 in the same cycle; o_front_bank=0; o_gen_count=0. After release, a fresh start completes a normal generation.
- Random 8x6 grids over 50 generations compared against a software reference model; all rows match, and o_gen_count=50.
